mem_port_arbiter: RTL and testbench

- Sequences one shared single-ported memory between the pipeline's fetch stage (read-only) and its MEM stage (load/store).
- Owns the memory handshake. Returns a registered one-cycle acknowledge with read data to the requester that won.
- Drives per-requester stall signals, which the hazard logic uses to freeze PC, IF/ID and the downstream pipeline registers.
- Round-robin arbitration. On a tie out of reset, the data port wins, so the older instruction completes first.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory command/response bus.
// The master modport is the arbiter's view; the slave modport is the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  // Handshakes: a requester holds *_req and its operands until its one-cycle *_ack.
  // The command transfers on a cycle with m_valid & m_ready, and m_valid and the
  // command fields stay stable until then. Exactly one m_resp_valid pulse follows,
  // for reads and writes alike, never in the same cycle as the acceptance.
  logic              m_valid;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic              m_resp_valid;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_resp_valid, m_rdata,
    output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall, m_valid, m_we, m_addr, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_resp_valid, m_rdata,
    input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall, m_valid, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and load/store.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE, with a WAIT timeout that sets sticky err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus,
  output logic               err,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              grant_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = err_q;
    // On a tie the port that did not win last time gets the memory.
    grant_data   = bus.d_req & (~bus.i_req | (last_grant_q == OWN_INST));

    case (state_q)
      S_IDLE: begin
        if (bus.i_req | bus.d_req) begin
          owner_d      = grant_data ? OWN_DATA : OWN_INST;
          last_grant_d = grant_data ? OWN_DATA : OWN_INST;
          addr_d       = grant_data ? bus.d_addr : bus.i_addr;
          we_d         = grant_data & bus.d_we;
          wdata_d      = grant_data ? bus.d_wdata : '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.m_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.m_resp_valid) begin
          if (owner_q == OWN_INST) begin
            i_rdata_d = bus.m_rdata;
          end else if (!we_q) begin
            d_rdata_d = bus.m_rdata;
          end
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          // Forced completion: the requester is released, its read data is left untouched.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_INST;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.m_valid = (state_q == S_ISSUE);
  assign bus.m_we    = we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

  assign bus.i_ack   = (state_q == S_DONE) & (owner_q == OWN_INST);
  assign bus.d_ack   = (state_q == S_DONE) & (owner_q == OWN_DATA);
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_stall = bus.i_req & ~bus.i_ack;
  assign bus.d_stall = bus.d_req & ~bus.d_ack;

  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model predicts grant order,
// ack cycles, command fields and returned data; one compare process checks every cycle.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          start;
    int          bp;
    int          ack_cyc;
    logic        to;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err;
  logic       busy;
  logic [1:0] dbg_state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  txn_t        exp_q[$];
  logic        m_last;
  int          m_last_ack;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  logic        exp_err = 1'b0;

  int          bp_cfg = 0;
  int          resp_cfg = 0;
  logic        force_resp = 1'b0;
  logic [31:0] mem_arr [logic [31:0]];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .err       (err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Model: a grant starts once the request is seen and the previous transaction has finished.
  task automatic expect_txn(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int req_cyc, input int bp, input int waits, input logic to);
    txn_t t;
    t.port    = port;
    t.we      = we;
    t.addr    = addr;
    t.wdata   = wdata;
    t.rdata   = rdata;
    t.start   = (req_cyc > m_last_ack + 1) ? req_cyc : m_last_ack + 1;
    t.bp      = bp;
    t.ack_cyc = t.start + 3 + bp + waits;
    t.to      = to;
    m_last_ack = t.ack_cyc;
    m_last     = port;
    exp_q.push_back(t);
  endtask

  task automatic wait_ack(input int budget, output logic port);
    int n;
    n = 0;
    port = 1'b0;
    tick();
    while (!(bus.i_ack || bus.d_ack) && n < budget) begin
      tick();
      n++;
    end
    if (bus.i_ack || bus.d_ack) begin
      port = bus.d_ack;
    end else begin
      checks++;
      errors++;
      $display("FAIL ack_wait got none expected ack within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    m_last = PORT_I;
    m_last_ack = cyc - 1;
  endtask

  // Memory responder: optional ready backpressure, then a response resp_cfg cycles after acceptance.
  initial begin : responder
    logic        issue_seen, pending, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    int          bp_left, resp_left;
    issue_seen = 1'b0; pending = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; bp_left = 0; resp_left = 0;
    mem_arr[32'h10] = 32'hDEADBEEF;
    mem_arr[32'h20] = 32'h12345678;
    mem_arr[32'h30] = 32'hCAFEF00D;
    mem_arr[32'h40] = 32'h0BADC0DE;
    bus.m_ready = 1'b0; bus.m_resp_valid = 1'b0; bus.m_rdata = '0;
    forever begin
      tick();
      bus.m_resp_valid = 1'b0;
      if (reset) begin
        bus.m_ready = 1'b0; pending = 1'b0; issue_seen = 1'b0;
      end else begin
        if (bus.m_ready) begin
          bus.m_ready = 1'b0; pending = 1'b1; issue_seen = 1'b0; resp_left = resp_cfg;
          if (cmd_we) mem_arr[cmd_addr] = cmd_wdata;
        end
        if (force_resp) begin
          bus.m_resp_valid = 1'b1; bus.m_rdata = 32'h77777777; force_resp = 1'b0;
        end else if (pending && resp_left == 0) begin
          bus.m_resp_valid = 1'b1;
          bus.m_rdata = (cmd_we || !mem_arr.exists(cmd_addr)) ? 32'h0 : mem_arr[cmd_addr];
          pending = 1'b0;
        end else if (pending && resp_left > 0) begin
          resp_left--;
        end
        if (bus.m_valid && !bus.m_ready) begin
          if (!issue_seen) begin
            issue_seen = 1'b1; bp_left = bp_cfg;
          end
          if (bp_left > 0) begin
            bp_left--;
          end else begin
            bus.m_ready = 1'b1; cmd_addr = bus.m_addr; cmd_we = bus.m_we; cmd_wdata = bus.m_wdata;
          end
        end
      end
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model's head transaction.
  initial begin : compare
    txn_t h;
    logic have, e_iack, e_dack, e_mvalid, e_busy;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        exp_i_rdata = '0; exp_d_rdata = '0; exp_err = 1'b0;
      end else begin
        have = (exp_q.size() > 0);
        if (have) h = exp_q[0];
        e_iack   = have && (cyc == h.ack_cyc) && (h.port == PORT_I);
        e_dack   = have && (cyc == h.ack_cyc) && (h.port == PORT_D);
        e_mvalid = have && (cyc >= h.start + 1) && (cyc <= h.start + 1 + h.bp);
        e_busy   = have && (cyc >= h.start + 1) && (cyc <= h.ack_cyc);
        if (have && cyc == h.ack_cyc) begin
          if (h.to) exp_err = 1'b1;
          else if (h.port == PORT_I) exp_i_rdata = h.rdata;
          else if (!h.we) exp_d_rdata = h.rdata;
        end
        chk("i_ack", bus.i_ack, e_iack);
        chk("d_ack", bus.d_ack, e_dack);
        chk("i_stall", bus.i_stall, bus.i_req & ~e_iack);
        chk("d_stall", bus.d_stall, bus.d_req & ~e_dack);
        chk("m_valid", bus.m_valid, e_mvalid);
        chk("busy", busy, e_busy);
        chk("err", err, exp_err);
        chk("i_rdata", bus.i_rdata, exp_i_rdata);
        chk("d_rdata", bus.d_rdata, exp_d_rdata);
        if (bus.m_valid && have) begin
          chk("m_addr", bus.m_addr, h.addr);
          chk("m_we", bus.m_we, h.we);
          if (h.we) chk("m_wdata", bus.m_wdata, h.wdata);
        end
        if (have && cyc >= h.ack_cyc) void'(exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int   c;
    logic p;
    logic [3:0] ord;
    do_reset();

    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_we", bus.m_we, 1'b0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_acks", {bus.i_ack, bus.d_ack}, 2'b00);
    chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
    chk("rst_err_busy", {err, busy}, 2'b00);

    // Fetch only, minimum latency.
    tick();
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    expect_txn(PORT_I, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, c, 0, 0, 1'b0);
    wait_ack(20, p);
    chk("t1_port", p, PORT_I);
    chk("t1_latency", cyc - c + 1, 4);
    bus.i_req = 1'b0;
    repeat (3) tick();
    chk("t1_i_rdata_hold", bus.i_rdata, 32'hDEADBEEF);

    // Tie out of reset: data store first, fetch next.
    tick();
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h5;
    expect_txn(PORT_D, 1'b1, 32'h80, 32'h5, 32'h0, c, 0, 0, 1'b0);
    expect_txn(PORT_I, 1'b0, 32'h20, 32'h0, 32'h12345678, c, 0, 0, 1'b0);
    wait_ack(20, p);
    chk("t2_first", p, PORT_D);
    chk("t2_m_wdata", bus.m_wdata, 32'h5);
    chk("t2_m_we", bus.m_we, 1'b1);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    wait_ack(20, p);
    chk("t2_second", p, PORT_I);
    bus.i_req = 1'b0;
    tick();
    chk("t2_d_rdata", bus.d_rdata, 32'h0);

    // Both held high for four transactions.
    tick();
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h30;
    for (int k = 0; k < 4; k++) begin
      if (m_last == PORT_I)
        expect_txn(PORT_D, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, c, 0, 0, 1'b0);
      else
        expect_txn(PORT_I, 1'b0, 32'h40, 32'h0, 32'h0BADC0DE, c, 0, 0, 1'b0);
    end
    ord = '0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, p);
      ord[3 - k] = p;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("t3_order", ord, 4'b1010);

    // Backpressure: five cycles of m_ready low.
    tick();
    bp_cfg = 5;
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    expect_txn(PORT_I, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, c, 5, 0, 1'b0);
    wait_ack(40, p);
    chk("t4_latency", cyc - c + 1, 9);
    bus.i_req = 1'b0;
    bp_cfg = 0;

    // Timeout, then a normal load.
    tick();
    resp_cfg = -1;
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    expect_txn(PORT_I, 1'b0, 32'h20, 32'h0, 32'h0, c, 0, TIMEOUT - 1, 1'b1);
    wait_ack(40, p);
    chk("t5_latency", cyc - c + 1, 11);
    chk("t5_err", err, 1'b1);
    chk("t5_i_rdata_kept", bus.i_rdata, 32'hDEADBEEF);
    bus.i_req = 1'b0;
    resp_cfg = 0;
    tick();
    c = cyc;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h30;
    expect_txn(PORT_D, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, c, 0, 0, 1'b0);
    wait_ack(20, p);
    chk("t5_after_port", p, PORT_D);
    bus.d_req = 1'b0;
    tick();
    chk("t5_err_sticky", err, 1'b1);
    chk("t5_d_rdata", bus.d_rdata, 32'hCAFEF00D);

    // Reset while waiting, late response afterwards.
    tick();
    resp_cfg = -1;
    c = cyc;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    expect_txn(PORT_D, 1'b0, 32'h40, 32'h0, 32'h0, c, 0, TIMEOUT - 1, 1'b1);
    tick();
    tick();
    chk("t6_busy_in_wait", busy, 1'b1);
    reset = 1'b1;
    bus.d_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_last = PORT_I;
    m_last_ack = cyc - 1;
    resp_cfg = 0;
    tick();
    tick();
    force_resp = 1'b1;
    repeat (3) tick();
    chk("t6_busy", busy, 1'b0);
    chk("t6_m_valid", bus.m_valid, 1'b0);
    chk("t6_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
    chk("t6_err", err, 1'b0);
    chk("t6_acks", {bus.i_ack, bus.d_ack}, 2'b00);

    // Recovery after reset.
    tick();
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    expect_txn(PORT_I, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, c, 0, 0, 1'b0);
    wait_ack(20, p);
    chk("t7_latency", cyc - c + 1, 4);
    bus.i_req = 1'b0;
    repeat (2) tick();
    chk("t7_i_rdata", bus.i_rdata, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
